// File: rtl/touch_poller_pkg.sv
// Shared I2C types plus the FT6206 touch-poller state encoding and constants.
package touch_poller_pkg;

    typedef enum logic {
        I2C_WRITE = 1'b0,
        I2C_READ  = 1'b1
    } i2c_transaction_t;

    typedef enum logic [2:0] {
        S_WAIT,
        S_REQ,
        S_XFER_LO,
        S_XFER_HI,
        S_DONE,
        S_ERR
    } touch_poller_state_t;

    localparam logic [6:0] FT_ADDR          = 7'h38;
    localparam logic [7:0] FT_REG_TD_STATUS = 8'h02;
    localparam int         FT_NUM_READS     = 5;

    // TD_STATUS low nibble above 2 is not a legal touch count; report no touch.
    function automatic logic [1:0] decode_touches(input logic [3:0] status);
        return (status > 4'd2) ? 2'd0 : status[1:0];
    endfunction

endpackage

// File: rtl/touch_poller.sv
// Polls an FT6206-class touch controller through the single-byte I2C controller
// and publishes touch count and P1 coordinates atomically.
module touch_poller
    import touch_poller_pkg::*;
#(
    parameter int         CLK_HZ         = 12_000_000,
    parameter logic [6:0] TARGET_ADDR    = FT_ADDR,
    parameter logic [7:0] START_REG      = FT_REG_TD_STATUS,
    parameter int         POLL_CYCLES    = CLK_HZ / 100,
    parameter int         TIMEOUT_CYCLES = 2_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    output i2c_transaction_t ctl_mode,
    input  logic             ctl_i_ready,
    output logic             ctl_i_valid,
    output logic [6:0]       ctl_i_addr,
    output logic [7:0]       ctl_i_data,
    output logic             ctl_o_ready,
    input  logic             ctl_o_valid,
    input  logic [7:0]       ctl_o_data,
    output logic [1:0]       touches,
    output logic [11:0]      touch_x,
    output logic [11:0]      touch_y,
    output logic             sample_valid,
    output logic             busy,
    output logic             last_error,
    output logic [7:0]       error_count
);

    localparam int NUM_READS = FT_NUM_READS;
    localparam int PW = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    touch_poller_state_t state_q, state_d;
    i2c_transaction_t    mode_q;
    logic [PW-1:0]       poll_cnt;
    logic [TW-1:0]       to_cnt;
    logic [2:0]          idx_q;
    logic [7:0]          rx_buf [NUM_READS];
    logic                store;
    logic                timed_out;
    logic                unused_bits;

    assign timed_out   = (to_cnt >= TW'(TIMEOUT_CYCLES - 1));
    assign ctl_mode    = mode_q;
    assign ctl_i_valid = (state_q == S_REQ);
    assign ctl_i_addr  = TARGET_ADDR;
    assign ctl_i_data  = (mode_q == I2C_WRITE) ? START_REG : 8'h00;
    assign ctl_o_ready = 1'b1;
    assign busy        = (state_q != S_WAIT);
    assign unused_bits = &{1'b0, rx_buf[0][7:4], rx_buf[1][7:4], rx_buf[3][7:4]};

    // Completion is tested before the timeout so it wins when both coincide.
    always_comb begin
        state_d = state_q;
        store   = 1'b0;
        case (state_q)
            S_WAIT:    if (poll_cnt == '0 && enable) state_d = S_REQ;
            S_REQ:     if (ctl_i_ready) state_d = S_XFER_LO;
                       else if (timed_out) state_d = S_ERR;
            S_XFER_LO: if (!ctl_i_ready) state_d = S_XFER_HI;
                       else if (timed_out) state_d = S_ERR;
            S_XFER_HI: begin
                if (ctl_i_ready) begin
                    if (mode_q == I2C_WRITE) begin
                        state_d = S_REQ;
                    end else if (ctl_o_valid) begin
                        store   = 1'b1;
                        state_d = (idx_q == 3'(NUM_READS - 1)) ? S_DONE : S_REQ;
                    end else begin
                        state_d = S_ERR;
                    end
                end else if (timed_out) begin
                    state_d = S_ERR;
                end
            end
            default:   state_d = S_WAIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_WAIT;
            mode_q       <= I2C_WRITE;
            poll_cnt     <= PW'(POLL_CYCLES - 1);
            to_cnt       <= '0;
            idx_q        <= '0;
            touches      <= '0;
            touch_x      <= '0;
            touch_y      <= '0;
            sample_valid <= 1'b0;
            last_error   <= 1'b0;
            error_count  <= '0;
        end else begin
            state_q      <= state_d;
            sample_valid <= 1'b0;

            if (state_d == S_WAIT && state_q != S_WAIT)
                poll_cnt <= PW'(POLL_CYCLES - 1);
            else if (state_q == S_WAIT && poll_cnt != '0)
                poll_cnt <= poll_cnt - 1'b1;

            if (state_d == S_REQ && state_q != S_REQ)
                to_cnt <= '0;
            else if (state_q inside {S_REQ, S_XFER_LO, S_XFER_HI})
                to_cnt <= to_cnt + 1'b1;

            if (state_q == S_WAIT && state_d == S_REQ) begin
                mode_q <= I2C_WRITE;
                idx_q  <= '0;
            end else if (state_q == S_XFER_HI && state_d == S_REQ) begin
                mode_q <= I2C_READ;
            end

            if (store)
                idx_q <= idx_q + 1'b1;

            if (state_q == S_DONE) begin
                touches      <= decode_touches(rx_buf[0][3:0]);
                touch_x      <= {rx_buf[1][3:0], rx_buf[2]};
                touch_y      <= {rx_buf[3][3:0], rx_buf[4]};
                sample_valid <= 1'b1;
                last_error   <= 1'b0;
            end

            if (state_q == S_ERR) begin
                last_error <= 1'b1;
                if (error_count != 8'hFF)
                    error_count <= error_count + 1'b1;
            end
        end
    end

    // NOTE: the receive buffer is deliberately left out of reset; every byte is
    // rewritten before S_DONE reads it, so resetting it would only add fan-out.
    always_ff @(posedge clk) begin
        if (store)
            rx_buf[idx_q] <= ctl_o_data;
    end

endmodule
